bram_mem_arbiter: RTL and testbench



---
 rtl/bram_mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_bram_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_mem_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM between two PicoRV32-style
// requesters. Each grant is guarded by a timeout that completes with ERR_RDATA.
module bram_mem_arbiter #(
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        s0_valid,
  input  logic        s0_instr,
  input  logic [31:0] s0_addr,
  input  logic [31:0] s0_wdata,
  input  logic [3:0]  s0_wstrb,
  output logic        s0_ready,
  output logic [31:0] s0_rdata,
  input  logic        s1_valid,
  input  logic        s1_instr,
  input  logic [31:0] s1_addr,
  input  logic [31:0] s1_wdata,
  input  logic [3:0]  s1_wstrb,
  output logic        s1_ready,
  output logic [31:0] s1_rdata,
  output logic        m_valid,
  output logic        m_instr,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_ready,
  input  logic [31:0] m_rdata,
  output logic        grant_id,
  output logic        busy,
  output logic        err_timeout,
  input  logic        err_clear
);

  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 7) ? $clog2(TIMEOUT_CYCLES) : 7;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_GAP} state_e;

  state_e            state_q, state_d;
  logic              prio_q, prio_d;
  logic              grant_q, grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              m_instr_q, m_instr_d;
  logic [31:0]       m_addr_q, m_addr_d;
  logic [31:0]       m_wdata_q, m_wdata_d;
  logic [3:0]        m_wstrb_q, m_wstrb_d;
  logic              err_q, err_d;
  logic              winner;
  logic              done;
  logic              timeout_hit;
  logic [31:0]       resp_rdata;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d     = state_q;
    prio_d      = prio_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    m_instr_d   = m_instr_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    m_wstrb_d   = m_wstrb_q;
    winner      = 1'b0;
    done        = 1'b0;
    timeout_hit = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (s0_valid || s1_valid) begin
          winner    = (s0_valid && s1_valid) ? prio_q : s1_valid;
          grant_d   = winner;
          m_instr_d = winner ? s1_instr : s0_instr;
          m_addr_d  = winner ? s1_addr  : s0_addr;
          m_wdata_d = winner ? s1_wdata : s0_wdata;
          m_wstrb_d = winner ? s1_wstrb : s0_wstrb;
          cnt_d     = '0;
          state_d   = S_BUSY;
        end
      end
      S_BUSY: begin
        timeout_hit = (cnt_q == CNT_LAST);
        if (m_ready || timeout_hit) begin
          done    = 1'b1;
          prio_d  = ~grant_q;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A real completion beats the terminal count, so no error is raised then.
  always_comb begin
    err_d = err_q;
    if (timeout_hit && !m_ready) err_d = 1'b1;
    else if (err_clear)          err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      prio_q    <= 1'b0;
      grant_q   <= 1'b0;
      cnt_q     <= '0;
      m_instr_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_wstrb_q <= '0;
      err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all flops update together from pre-edge values.
      state_q   <= state_d;
      prio_q    <= prio_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      m_instr_q <= m_instr_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_wstrb_q <= m_wstrb_d;
      err_q     <= err_d;
    end
  end

  assign resp_rdata  = m_ready ? m_rdata : ERR_RDATA;
  assign s0_ready    = done && !grant_q;
  assign s1_ready    = done &&  grant_q;
  assign s0_rdata    = s0_ready ? resp_rdata : 32'h0;
  assign s1_rdata    = s1_ready ? resp_rdata : 32'h0;

  assign m_valid     = (state_q == S_BUSY);
  assign busy        = (state_q == S_BUSY);
  assign m_instr     = m_instr_q;
  assign m_addr      = m_addr_q;
  assign m_wdata     = m_wdata_q;
  assign m_wstrb     = m_wstrb_q;
  assign grant_id    = grant_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_bram_mem_arbiter.sv
// Self-checking bench for bram_mem_arbiter: BRAM model, per-port scoreboard,
// a vector table of single transactions and hand-written corner sequences.
module tb_bram_mem_arbiter;

  logic        clk, resetn;
  logic        s0_valid, s0_instr, s0_ready, s1_valid, s1_instr, s1_ready;
  logic [31:0] s0_addr, s0_wdata, s0_rdata, s1_addr, s1_wdata, s1_rdata;
  logic [3:0]  s0_wstrb, s1_wstrb, m_wstrb;
  logic        m_valid, m_instr, m_ready, grant_id, busy, err_timeout, err_clear;
  logic [31:0] m_addr, m_wdata, m_rdata;

  bram_mem_arbiter #(.TIMEOUT_CYCLES(8), .ERR_RDATA(32'hDEADBEEF)) dut (
    .clk(clk), .resetn(resetn),
    .s0_valid(s0_valid), .s0_instr(s0_instr), .s0_addr(s0_addr), .s0_wdata(s0_wdata),
    .s0_wstrb(s0_wstrb), .s0_ready(s0_ready), .s0_rdata(s0_rdata),
    .s1_valid(s1_valid), .s1_instr(s1_instr), .s1_addr(s1_addr), .s1_wdata(s1_wdata),
    .s1_wstrb(s1_wstrb), .s1_ready(s1_ready), .s1_rdata(s1_rdata),
    .m_valid(m_valid), .m_instr(m_instr), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_ready(m_ready), .m_rdata(m_rdata),
    .grant_id(grant_id), .busy(busy), .err_timeout(err_timeout), .err_clear(err_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // BRAM model: answers after mem_lat wait cycles, or never while mem_stall is set.
  logic [31:0] mem [0:4095];
  int          mem_lat = 1;
  bit          mem_stall = 1'b0;
  int          lat_cnt = 0;

  assign m_ready = m_valid && !mem_stall && (lat_cnt >= mem_lat);
  assign m_rdata = (m_wstrb == 4'h0) ? mem[m_addr[13:2]] : 32'h0;

  always @(posedge clk) begin
    lat_cnt <= (m_valid && !m_ready) ? lat_cnt + 1 : 0;
    if (m_valid && m_ready) begin
      for (int b = 0; b < 4; b++)
        if (m_wstrb[b]) mem[m_addr[13:2]][8*b +: 8] <= m_wdata[8*b +: 8];
    end
  end

  // Scoreboard: expected rdata queued per port at drive time, popped on ready.
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  bit          grant_log[$];
  logic [31:0] last_addr;
  logic [3:0]  last_wstrb;

  always @(negedge clk) begin
    if (resetn) begin
      if (s0_ready && s1_ready) check("dual_ready", 32'd1, 32'd0);
      if (s0_ready) begin
        if (exp_q0.size() == 0) check("s0_unexpected_ready", 32'd1, 32'd0);
        else check("s0_rdata", s0_rdata, exp_q0.pop_front());
        check("s1_rdata_idle", s1_rdata, 32'h0);
        grant_log.push_back(1'b0);
        last_addr  = m_addr;
        last_wstrb = m_wstrb;
      end
      if (s1_ready) begin
        if (exp_q1.size() == 0) check("s1_unexpected_ready", 32'd1, 32'd0);
        else check("s1_rdata", s1_rdata, exp_q1.pop_front());
        check("s0_rdata_idle", s0_rdata, 32'h0);
        grant_log.push_back(1'b1);
        last_addr  = m_addr;
        last_wstrb = m_wstrb;
      end
    end
  end

  // Drive one request, wait (bounded) for its ready, drop valid in the GAP cycle.
  task automatic do_txn(input bit port, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input logic [31:0] exp_rdata,
                        output int busy_cyc, output int first_busy);
    int  n = 0;
    bit  seen = 1'b0;
    busy_cyc   = 0;
    first_busy = 0;
    @(posedge clk); #1;
    if (port) begin
      exp_q1.push_back(exp_rdata);
      s1_valid = 1'b1; s1_addr = addr; s1_wdata = wdata; s1_wstrb = wstrb;
    end else begin
      exp_q0.push_back(exp_rdata);
      s0_valid = 1'b1; s0_addr = addr; s0_wdata = wdata; s0_wstrb = wstrb;
    end
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      if (busy) begin
        busy_cyc++;
        if (first_busy == 0) first_busy = n;
      end
      seen = port ? s1_ready : s0_ready;
    end
    if (!seen) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if (port) s1_valid = 1'b0; else s0_valid = 1'b0;
    check("gap_m_valid", {31'b0, m_valid}, 32'd0);
  endtask

  typedef struct {
    bit          port;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          lat;
    bit          stall;
    logic [31:0] exp_rdata;
    int          exp_busy;
    bit          exp_err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int bc, fb;
    vecs[0] = '{1'b0, 32'h0000_0100, 32'h0,         4'h0, 1, 1'b0, 32'h1234_5678, 2, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_1004, 32'hAABB_CCDD, 4'h3, 0, 1'b0, 32'h0,         1, 1'b0};
    vecs[2] = '{1'b0, 32'h0000_1004, 32'h0,         4'h0, 2, 1'b0, 32'h1122_CCDD, 3, 1'b0};
    vecs[3] = '{1'b0, 32'h0000_0100, 32'h0,         4'h0, 1, 1'b1, 32'hDEAD_BEEF, 8, 1'b1};
    vecs[4] = '{1'b1, 32'h0000_0200, 32'h0,         4'h0, 7, 1'b0, 32'hCAFE_F00D, 8, 1'b0};
    vecs[5] = '{1'b0, 32'h0000_0200, 32'h5566_7788, 4'hF, 0, 1'b0, 32'h0,         1, 1'b0};
    vecs[6] = '{1'b1, 32'h0000_0200, 32'h0,         4'h0, 3, 1'b0, 32'h5566_7788, 4, 1'b0};
    vecs[7] = '{1'b1, 32'h0000_0300, 32'h0,         4'h0, 1, 1'b1, 32'hDEAD_BEEF, 8, 1'b1};

    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[12'h040] = 32'h1234_5678;
    mem[12'h401] = 32'h1122_3344;
    mem[12'h080] = 32'hCAFE_F00D;

    resetn = 1'b0; err_clear = 1'b0;
    s0_valid = 1'b0; s0_instr = 1'b0; s0_addr = '0; s0_wdata = '0; s0_wstrb = '0;
    s1_valid = 1'b0; s1_instr = 1'b0; s1_addr = '0; s1_wdata = '0; s1_wstrb = '0;
    #2;
    check("rst_m_valid",  {31'b0, m_valid},     32'd0);
    check("rst_busy",     {31'b0, busy},        32'd0);
    check("rst_grant_id", {31'b0, grant_id},    32'd0);
    check("rst_err",      {31'b0, err_timeout}, 32'd0);
    check("rst_m_addr",   m_addr,               32'd0);
    check("rst_m_wdata",  m_wdata,              32'd0);
    check("rst_m_wstrb",  {28'b0, m_wstrb},     32'd0);
    check("rst_readies",  {30'b0, s1_ready, s0_ready}, 32'd0);
    #10 resetn = 1'b1;

    // Both ports request continuously from reset: grants must alternate starting at port 0.
    mem_lat = 1;
    fork
      for (int k = 0; k < 4; k++) begin
        int b0, f0;
        do_txn(1'b0, 32'h0000_0100, 32'h0, 4'h0, 32'h1234_5678, b0, f0);
      end
      for (int k = 0; k < 4; k++) begin
        int b1, f1;
        do_txn(1'b1, 32'h0000_0200, 32'h0, 4'h0, 32'hCAFE_F00D, b1, f1);
      end
    join
    check("rr_count", grant_log.size(), 32'd8);
    for (int k = 0; k < grant_log.size(); k++)
      check($sformatf("rr_grant_%0d", k), {31'b0, grant_log[k]}, k % 2);

    for (int i = 0; i < 8; i++) begin
      err_clear = 1'b1;
      @(posedge clk); #1;
      err_clear = 1'b0;
      check($sformatf("v%0d_err_cleared", i), {31'b0, err_timeout}, 32'd0);
      mem_lat   = vecs[i].lat;
      mem_stall = vecs[i].stall;
      do_txn(vecs[i].port, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].exp_rdata, bc, fb);
      mem_stall = 1'b0;
      check($sformatf("v%0d_busy_cycles", i), bc, vecs[i].exp_busy);
      check($sformatf("v%0d_grant_latency", i), fb, 32'd2);
      check($sformatf("v%0d_err", i), {31'b0, err_timeout}, {31'b0, vecs[i].exp_err});
      check($sformatf("v%0d_m_addr", i), last_addr, vecs[i].addr);
      check($sformatf("v%0d_m_wstrb", i), {28'b0, last_wstrb}, {28'b0, vecs[i].wstrb});
      check($sformatf("v%0d_grant_id", i), {31'b0, grant_id}, {31'b0, vecs[i].port});
    end

    // Timeout set in the same cycle as err_clear: set must win.
    err_clear = 1'b1;
    @(posedge clk); #1;
    check("pre_set_clear", {31'b0, err_timeout}, 32'd0);
    mem_stall = 1'b1;
    do_txn(1'b0, 32'h0000_0100, 32'h0, 4'h0, 32'hDEAD_BEEF, bc, fb);
    mem_stall = 1'b0;
    check("set_beats_clear", {31'b0, err_timeout}, 32'd1);
    err_clear = 1'b0;
    @(posedge clk); #1;
    check("err_sticky", {31'b0, err_timeout}, 32'd1);
    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
    check("err_clear", {31'b0, err_timeout}, 32'd0);

    // Requester changes its address while granted: the latched one is used.
    mem_lat = 3;
    fork
      do_txn(1'b0, 32'h0000_0100, 32'h0, 4'h0, 32'h1234_5678, bc, fb);
      begin
        repeat (3) @(posedge clk);
        #2 s0_addr = 32'h0000_0200;
      end
    join
    check("addr_latched", last_addr, 32'h0000_0100);

    // Reset during BUSY aborts a write without a ready pulse or memory update.
    mem_stall = 1'b1;
    @(posedge clk); #1;
    s0_valid = 1'b1; s0_addr = 32'h0000_0100; s0_wdata = 32'hFFFF_FFFF; s0_wstrb = 4'hF;
    repeat (3) @(negedge clk);
    check("pre_reset_busy", {31'b0, busy}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("arst_m_valid", {31'b0, m_valid}, 32'd0);
    check("arst_busy",    {31'b0, busy},    32'd0);
    check("arst_ready",   {31'b0, s0_ready}, 32'd0);
    check("arst_m_addr",  m_addr,           32'd0);
    check("arst_m_wstrb", {28'b0, m_wstrb}, 32'd0);
    s0_valid = 1'b0; s0_wstrb = 4'h0;
    mem_stall = 1'b0;
    @(posedge clk); #2 resetn = 1'b1;
    check("no_write_replay", mem[12'h040], 32'h1234_5678);
    mem_lat = 1;
    do_txn(1'b1, 32'h0000_0200, 32'h0, 4'h0, 32'h5566_7788, bc, fb);
    check("post_rst_latency", fb, 32'd2);
    check("post_rst_grant", {31'b0, grant_id}, 32'd1);

    check("sb_q0_empty", exp_q0.size(), 32'd0);
    check("sb_q1_empty", exp_q1.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
